alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 135 +++++++++++++
 tb/tb_alu_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared ALU: IDLE -> EXEC -> RESP, with a
// fixed two-cycle latency from accept to response. Define ALU_ARB_ROUND_ROBIN_EN for a round-robin tie-break.
module alu_arbiter #(
  parameter int BITS = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  input  logic            req1_valid,
  output logic            req0_ready,
  output logic            req1_ready,
  input  logic [BITS-1:0] req0_a,
  input  logic [BITS-1:0] req0_b,
  input  logic [BITS-1:0] req1_a,
  input  logic [BITS-1:0] req1_b,
  input  logic [3:0]      req0_ctrl,
  input  logic [3:0]      req1_ctrl,
  input  logic            req0_flagin,
  input  logic            req1_flagin,
  output logic [BITS-1:0] alu_a,
  output logic [BITS-1:0] alu_b,
  output logic [3:0]      alu_ctrl,
  output logic            alu_flagin,
  input  logic [BITS-1:0] alu_result,
  input  logic            alu_c,
  input  logic            alu_flags,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic            resp_id,
  output logic [BITS-1:0] resp_result,
  output logic            resp_c,
  output logic            resp_flags
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [BITS-1:0] a;
    logic [BITS-1:0] b;
    logic [3:0]      ctrl;
    logic            flagin;
  } req_t;

  state_t          state;
  req_t [1:0]      req_in;
  logic [1:0]      vld;
  logic [1:0]      gnt;
  logic            gnt_id;
  logic            op_id;

  assign req_in[0] = '{a: req0_a, b: req0_b, ctrl: req0_ctrl, flagin: req0_flagin};
  assign req_in[1] = '{a: req1_a, b: req1_b, ctrl: req1_ctrl, flagin: req1_flagin};
  assign vld       = {req1_valid, req0_valid};

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic last;

  always_comb begin
    gnt = '0;
    if (state == IDLE) begin
      if (vld == 2'b11) gnt = last ? 2'b01 : 2'b10;
      else              gnt = vld;
    end
  end

  // last=1 out of reset so requester 0 wins the first tie
  always_ff @(posedge clk) begin
    if (rst)       last <= 1'b1;
    else if (|gnt) last <= gnt_id;
  end
`else
  always_comb begin
    gnt = '0;
    if (state == IDLE) gnt = {vld[1] & ~vld[0], vld[0]};
  end
`endif

  assign gnt_id     = gnt[1];
  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  // alu_* double as the operand registers: loaded on accept, cleared leaving EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      op_id       <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_ctrl    <= '0;
      alu_flagin  <= 1'b0;
      resp_valid  <= 1'b0;
      resp_id     <= 1'b0;
      resp_result <= '0;
      resp_c      <= 1'b0;
      resp_flags  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|gnt) begin
            state      <= EXEC;
            op_id      <= gnt_id;
            alu_a      <= req_in[gnt_id].a;
            alu_b      <= req_in[gnt_id].b;
            alu_ctrl   <= req_in[gnt_id].ctrl;
            alu_flagin <= req_in[gnt_id].flagin;
          end
        end
        EXEC: begin
          state       <= RESP;
          alu_a       <= '0;
          alu_b       <= '0;
          alu_ctrl    <= '0;
          alu_flagin  <= 1'b0;
          resp_valid  <= 1'b1;
          resp_id     <= op_id;
          resp_result <= alu_result;
          resp_c      <= alu_c;
          resp_flags  <= alu_flags;
        end
        RESP: begin
          if (resp_ready) begin
            state       <= IDLE;
            resp_valid  <= 1'b0;
            resp_id     <= 1'b0;
            resp_result <= '0;
            resp_c      <= 1'b0;
            resp_flags  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with an XOR ALU stub; expectations follow
// ALU_ARB_ROUND_ROBIN_EN when the build defines it.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0] req0_ctrl = '0, req1_ctrl = '0;
  logic       req0_flagin = 1'b0, req1_flagin = 1'b0;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [3:0] alu_ctrl;
  logic       alu_flagin, alu_c, alu_flags;
  logic       resp_valid, resp_ready = 1'b1, resp_id, resp_c, resp_flags;
  logic [7:0] resp_result;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign alu_result = alu_a ^ alu_b;
  assign alu_c      = alu_a[7];
  assign alu_flags  = alu_flagin;

  alu_arbiter #(.BITS(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_ctrl(req0_ctrl), .req1_ctrl(req1_ctrl),
    .req0_flagin(req0_flagin), .req1_flagin(req1_flagin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_flagin(alu_flagin),
    .alu_result(alu_result), .alu_c(alu_c), .alu_flags(alu_flags),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_c(resp_c), .resp_flags(resp_flags)
  );

  typedef struct {
    logic       v0, v1;
    logic [7:0] a0, b0, a1, b1;
    logic [3:0] c0, c1;
    logic       f0, f1;
    logic       eid;
    logic [7:0] eres;
    logic       ec, ef;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Starts in IDLE just after a rising edge; covers accept, EXEC and RESP.
  task automatic run_op(input vec_t v, input logic hold, input logic rrdy);
    req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0; req0_ctrl = v.c0; req0_flagin = v.f0;
    req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1; req1_ctrl = v.c1; req1_flagin = v.f1;
    resp_ready = rrdy;
    #1;
    chk("req0_ready", req0_ready, !v.eid);
    chk("req1_ready", req1_ready, v.eid);
    @(posedge clk); #1;
    if (!hold) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    chk("exec_alu_a", alu_a, v.eid ? v.a1 : v.a0);
    chk("exec_alu_b", alu_b, v.eid ? v.b1 : v.b0);
    chk("exec_alu_ctrl", alu_ctrl, v.eid ? v.c1 : v.c0);
    chk("exec_alu_flagin", alu_flagin, v.eid ? v.f1 : v.f0);
    chk("exec_ready", req0_ready | req1_ready, 0);
    chk("exec_resp_valid", resp_valid, 0);
    @(posedge clk); #1;
    chk("resp_valid", resp_valid, 1);
    chk("resp_id", resp_id, v.eid);
    chk("resp_result", resp_result, v.eres);
    chk("resp_c", resp_c, v.ec);
    chk("resp_flags", resp_flags, v.ef);
    chk("resp_alu_a_zero", alu_a, 0);
    chk("resp_ready_none", req0_ready | req1_ready, 0);
    if (rrdy) begin
      @(posedge clk); #1;
      chk("idle_resp_valid", resp_valid, 0);
      chk("idle_resp_result", resp_result, 0);
    end
  endtask

  initial begin
    vec_t v;
    logic exp_ids [4];
    logic seen;

    //          v0 v1  a0     b0     a1     b1     c0    c1    f0 f1  id res    c  f
    tbl[0] = '{0, 1, 8'h00, 8'h00, 8'h80, 8'h01, 4'h0, 4'h9, 0, 0, 1, 8'h81, 1, 0};
    tbl[1] = '{1, 0, 8'hD6, 8'h03, 8'h00, 8'h00, 4'h8, 4'h0, 1, 0, 0, 8'hD5, 1, 1};
    tbl[2] = '{1, 0, 8'h7F, 8'h80, 8'h00, 8'h00, 4'h3, 4'h0, 1, 0, 0, 8'hFF, 0, 1};
    tbl[3] = '{1, 0, 8'hFF, 8'hFF, 8'h00, 8'h00, 4'hF, 4'h0, 0, 0, 0, 8'h00, 1, 0};
    tbl[4] = '{0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 4'h0, 0, 1, 1, 8'h00, 0, 1};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_ctrl", alu_ctrl, 0);
    chk("rst_resp_result", resp_result, 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_op(tbl[i], 1'b0, 1'b1);

    // simultaneous valids, held across four back-to-back ops
`ifdef ALU_ARB_ROUND_ROBIN_EN
    exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_ids = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    for (int i = 0; i < 4; i++) begin
      v = '{1, 1, 8'h11, 8'h22, 8'h33, 8'h44, 4'h2, 4'h5, 1, 0, exp_ids[i],
            exp_ids[i] ? 8'h77 : 8'h33, 0, !exp_ids[i]};
      run_op(v, 1'b1, 1'b1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // back-pressure in RESP with req1 waiting
    v = '{1, 0, 8'h5A, 8'hA5, 8'h00, 8'h00, 4'h1, 4'h0, 0, 0, 0, 8'hFF, 0, 0};
    run_op(v, 1'b0, 1'b0);
    req1_valid = 1'b1; req1_a = 8'h01; req1_b = 8'h02; req1_ctrl = 4'h7; req1_flagin = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_resp_valid", resp_valid, 1);
      chk("bp_resp_id", resp_id, 0);
      chk("bp_resp_result", resp_result, 8'hFF);
      chk("bp_resp_cf", {resp_c, resp_flags}, 2'b00);
      chk("bp_no_ready", req0_ready | req1_ready, 0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_resp_valid", resp_valid, 0);
    chk("bp_idle_resp_result", resp_result, 0);
    chk("bp_idle_req1_ready", req1_ready, 1);
    v = '{0, 1, 8'h00, 8'h00, 8'h01, 8'h02, 4'h0, 4'h7, 0, 1, 1, 8'h03, 0, 1};
    run_op(v, 1'b0, 1'b1);

    // reset while in EXEC discards the operation
    req1_valid = 1'b1; req1_a = 8'h0F; req1_b = 8'hF0; req1_ctrl = 4'h4; req1_flagin = 1'b1;
    #1;
    chk("rx_req1_ready", req1_ready, 1);
    @(posedge clk); #1;
    chk("rx_exec_alu_a", alu_a, 8'h0F);
    req1_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rx_alu_a", alu_a, 0);
    chk("rx_alu_b", alu_b, 0);
    chk("rx_alu_ctrl", alu_ctrl, 0);
    chk("rx_resp_valid", resp_valid, 0);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (resp_valid) seen = 1'b1;
    end
    chk("rx_no_resp", seen, 0);
    v = '{1, 1, 8'hC3, 8'h3C, 8'h0F, 8'hF0, 4'h6, 4'h4, 1, 1, 0, 8'hFF, 1, 1};
    run_op(v, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
